// File: rtl/neuro_pkg.sv
// Shared definitions for the parity-machine random-sequence front end.
// Holds the LFSR width, wrap state and default seed, the scheduler state
// encoding, and helper functions for the LFSR step and seed selection.
// No ports (package).
package neuro_pkg;

    localparam int               LFSR_W    = 13;
    localparam logic [LFSR_W-1:0] LFSR_WRAP = 13'h220;
    localparam logic [LFSR_W-1:0] SEED_A    = 13'h16B8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SEED  = 2'd2
    } sched_state_t;

    // XNOR-tap step on bits 12,3,2,0. The wrap state is forced to zero, which
    // keeps the cycle away from the all-ones lock-up state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        if (cur == LFSR_WRAP) begin
            return '0;
        end
        return {cur[LFSR_W-2:0], ~(cur[12] ^ cur[3] ^ cur[2] ^ cur[0])};
    endfunction

    function automatic logic [LFSR_W-1:0] seed_sel(input logic [2:0]        seed_no,
                                                    input logic [LFSR_W-1:0] seed_val);
        case (seed_no)
            3'd1, 3'd2: return SEED_A;
            3'd7:       return seed_val;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_rr_sched_rr_pick.sv
// Combinational round-robin priority picker.
// Returns the first requester with req=1 at or after ptr, wrapping at N.
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  index searched first
//   onehot out N   one-hot of the winner (0 when nothing requests)
//   idx    out PW  index of the winner (0 when nothing requests)
//   any    out 1   at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                           = 1'b1;
                onehot[(int'(ptr) + k) % N]   = 1'b1;
                idx                           = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one 13-bit LFSR sequence among NREQ
// requesters. Each grant is a burst of words handed out with valid/ready;
// the LFSR only advances on accepted words so every burst is a contiguous
// slice of the sequence.
// Ports:
//   clk        in   1           clock
//   rst        in   1           synchronous active-high reset
//   seed_no    in   3           seed select (1,2 -> SEED_A, 7 -> seed_val, else 0)
//   seed_val   in   13          explicit seed for seed_no==7
//   reseed     in   1           pulse: reload LFSR (deferred to end of a burst)
//   req        in   NREQ        level requests
//   req_len    in   NREQ*LEN_W  per-requester burst length (0 means 1)
//   rnd_ready  in   NREQ        per-requester ready, granted bit used
//   gnt        out  NREQ        one-hot grant held for the burst
//   rnd_data   out  13          current LFSR state
//   rnd_valid  out  1           word valid to granted requester
//   seq_wrap   out  1           pulse when an accepted step wraps to zero
//   busy       out  1           granting or reseeding
//
// state   | meaning
// S_IDLE  | arbitrate; pending reseed wins over requests
// S_GRANT | burst in progress, rnd_valid high
// S_SEED  | one cycle reloading the LFSR
module lfsr_rr_sched
    import neuro_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              seed_no,
    input  logic [LFSR_W-1:0]       seed_val,
    input  logic                    reseed,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    input  logic [NREQ-1:0]         rnd_ready,
    output logic [NREQ-1:0]         gnt,
    output logic [LFSR_W-1:0]       rnd_data,
    output logic                    rnd_valid,
    output logic                    seq_wrap,
    output logic                    busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t      state;
    logic [LFSR_W-1:0] lfsr;
    logic [LEN_W-1:0]  cnt;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     ptr;
    logic              pend;

    logic [NREQ-1:0]   pick_oh;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic [LEN_W-1:0]  len_sel;
    logic              acc;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign len_sel  = req_len[int'(pick_idx) * LEN_W +: LEN_W];
    assign acc      = rnd_valid & rnd_ready[gidx];
    assign rnd_data = lfsr;
    assign busy     = (state == S_GRANT) || (state == S_SEED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            rnd_valid <= 1'b0;
            seq_wrap  <= 1'b0;
            ptr       <= '0;
            pend      <= 1'b0;
            lfsr      <= seed_sel(seed_no, seed_val);
        end else begin
            seq_wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pend || reseed) begin
                        state <= S_SEED;
                    end else if (pick_any) begin
                        gnt       <= pick_oh;
                        gidx      <= pick_idx;
                        cnt       <= (len_sel == '0) ? LEN_W'(1) : len_sel;
                        rnd_valid <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Reseed waits so the running burst stays on one sequence.
                    if (reseed) begin
                        pend <= 1'b1;
                    end
                    if (acc) begin
                        lfsr     <= lfsr_next(lfsr);
                        seq_wrap <= (lfsr == LFSR_WRAP);
                        if (cnt == LEN_W'(1)) begin
                            gnt       <= '0;
                            rnd_valid <= 1'b0;
                            cnt       <= '0;
                            ptr       <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                            state     <= S_IDLE;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                end
                S_SEED: begin
                    lfsr  <= seed_sel(seed_no, seed_val);
                    pend  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rr_sched.sv
module tb_lfsr_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  seed_no;
    logic [12:0] seed_val;
    logic        reseed;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  rnd_ready;
    logic [3:0]  gnt;
    logic [12:0] rnd_data;
    logic        rnd_valid;
    logic        seq_wrap;
    logic        busy;

    int total = 0;
    int bad   = 0;

    lfsr_rr_sched #(.NREQ(4), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_no   (seed_no),
        .seed_val  (seed_val),
        .reseed    (reseed),
        .req       (req),
        .req_len   (req_len),
        .rnd_ready (rnd_ready),
        .gnt       (gnt),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .seq_wrap  (seq_wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference step: shift left, feed back the inverted parity of bits 12,3,2,0.
    function automatic logic [12:0] m_next(input logic [12:0] x);
        int v;
        int par;
        v = int'(x);
        if (v == 32'h220) return 13'h0000;
        par = ((v >> 12) + (v >> 3) + (v >> 2) + v) & 1;
        return 13'(((v << 1) & 32'h1FFF) | (1 - par));
    endfunction

    function automatic int m_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] sn);
        rst = 1'b1; seed_no = sn; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0; rnd_ready = '0; req_len = '0; reseed = 1'b0; seed_val = '0;
        do_reset(3'd1);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (seq_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", seq_wrap); end
        total++; if (rnd_data !== 13'h16B8) begin bad++; $display("FAIL reset_data got=%h exp=16b8", rnd_data); end
    endtask

    task automatic test_single();
        logic [12:0] m;
        m = 13'h16B8;
        req = 4'b0001; req_len = 16'h0003; rnd_ready = 4'b1111;
        step();
        req = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        for (int w = 0; w < 3; w++) begin
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt w=%0d got=%b exp=0001", w, gnt); end
            total++; if (rnd_data !== m) begin bad++; $display("FAIL single_data w=%0d got=%h exp=%h", w, rnd_data, m); end
            step();
            m = m_next(m);
        end
        total++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) begin bad++; $display("FAIL single_end gnt=%b valid=%b exp=0000/0", gnt, rnd_valid); end
    endtask

    task automatic test_rr();
        logic [12:0] m;
        logic [3:0]  exp_g;
        do_reset(3'd1);
        m = 13'h16B8;
        req = 4'b1111; req_len = 16'h1111; rnd_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, exp_g); end
            total++; if (rnd_data !== m) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, rnd_data, m); end
            step();
            m = m_next(m);
            total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_idle k=%0d got=%b exp=0000", k, gnt); end
        end
        req = '0;
        step();
    endtask

    task automatic test_backpressure();
        logic [12:0] d0;
        req = 4'b0001; req_len = 16'h0002; rnd_ready = 4'b1110;
        step();
        req = '0;
        d0 = rnd_data;
        for (int c = 0; c < 5; c++) begin
            step();
            total++; if (rnd_valid !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL bp_hold c=%0d valid=%b gnt=%b exp=1/0001", c, rnd_valid, gnt); end
            total++; if (rnd_data !== d0) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, rnd_data, d0); end
        end
        rnd_ready = 4'b0001;
        step();
        total++; if (rnd_data !== m_next(d0) || gnt !== 4'b0001) begin bad++; $display("FAIL bp_first data=%h gnt=%b exp=%h/0001", rnd_data, gnt, m_next(d0)); end
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL bp_end got=%b exp=0000", gnt); end
    endtask

    task automatic test_wrap();
        req = '0; seed_no = 3'd7; seed_val = 13'h0220; reseed = 1'b1;
        step();
        reseed = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap_seedbusy got=%b exp=1", busy); end
        step();
        total++; if (rnd_data !== 13'h0220 || busy !== 1'b0) begin bad++; $display("FAIL wrap_seeded data=%h busy=%b exp=0220/0", rnd_data, busy); end
        req = 4'b0001; req_len = 16'h0002; rnd_ready = 4'b1111;
        step();
        req = '0;
        total++; if (rnd_data !== 13'h0220 || rnd_valid !== 1'b1) begin bad++; $display("FAIL wrap_w0 data=%h valid=%b exp=0220/1", rnd_data, rnd_valid); end
        step();
        total++; if (rnd_data !== 13'h0000 || seq_wrap !== 1'b1) begin bad++; $display("FAIL wrap_w1 data=%h wrap=%b exp=0000/1", rnd_data, seq_wrap); end
        step();
        total++; if (seq_wrap !== 1'b0 || rnd_data !== 13'h0001) begin bad++; $display("FAIL wrap_after wrap=%b data=%h exp=0/0001", seq_wrap, rnd_data); end
    endtask

    task automatic test_reseed_mid();
        logic [12:0] m;
        m = rnd_data;
        seed_no = 3'd1;
        req = 4'b0001; req_len = 16'h0004; rnd_ready = 4'b1111;
        step();
        for (int w = 0; w < 4; w++) begin
            reseed = (w == 1 || w == 2);
            total++; if (rnd_data !== m || gnt !== 4'b0001) begin bad++; $display("FAIL rsm_word w=%0d data=%h gnt=%b exp=%h/0001", w, rnd_data, gnt, m); end
            step();
            m = m_next(m);
        end
        reseed = 1'b0;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rsm_end got=%b exp=0000", gnt); end
        req_len = 16'h0001;
        step();
        total++; if (busy !== 1'b1 || gnt !== 4'b0000 || rnd_data !== m) begin bad++; $display("FAIL rsm_seed busy=%b gnt=%b data=%h exp=1/0000/%h", busy, gnt, rnd_data, m); end
        step();
        step();
        total++; if (gnt !== 4'b0001 || rnd_data !== 13'h16B8) begin bad++; $display("FAIL rsm_new gnt=%b data=%h exp=0001/16b8", gnt, rnd_data); end
        req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        req = 4'b0010; req_len = 16'h0050; rnd_ready = 4'b1111;
        step();
        step();
        rst = 1'b1; seed_no = 3'd2;
        step();
        rst = 1'b0;
        total++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_out gnt=%b valid=%b busy=%b exp=0000/0/0", gnt, rnd_valid, busy); end
        total++; if (rnd_data !== 13'h16B8) begin bad++; $display("FAIL rstmid_data got=%h exp=16b8", rnd_data); end
        req = 4'b1111; req_len = 16'h1111;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rstmid_ptr got=%b exp=0001", gnt); end
        req = '0;
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rstmid_len got=%b exp=0000", gnt); end
    endtask

    task automatic test_random();
        logic [12:0] m;
        logic [3:0]  app_req;
        logic [15:0] app_len;
        logic        pre_valid;
        logic [12:0] pre_data;
        int          mptr, g, rem, fld;
        bit          active;
        do_reset(3'd1);
        m = 13'h16B8; mptr = 0; active = 0; g = 0; rem = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            rnd_ready = 4'($urandom_range(0, 15));
            req_len   = 16'($urandom);
            app_req   = req;
            app_len   = req_len;
            pre_valid = rnd_valid;
            pre_data  = rnd_data;
            if (active && pre_valid && rnd_ready[g]) begin
                total++; if (pre_data !== m) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, pre_data, m); end
                m = m_next(m);
                rem--;
            end
            step();
            if (active) begin
                if (rem == 0) begin
                    total++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) begin bad++; $display("FAIL rnd_end cyc=%0d gnt=%b valid=%b exp=0000/0", cyc, gnt, rnd_valid); end
                    mptr = (g + 1) % 4;
                    active = 0;
                end else begin
                    total++; if (gnt !== (4'b0001 << g) || rnd_valid !== 1'b1) begin bad++; $display("FAIL rnd_hold cyc=%0d gnt=%b valid=%b exp=%b/1", cyc, gnt, rnd_valid, 4'b0001 << g); end
                end
            end else if (app_req != 4'b0000) begin
                g   = m_pick(app_req, mptr);
                fld = int'((app_len >> (g * 4)) & 16'h000F);
                rem = (fld == 0) ? 1 : fld;
                active = 1;
                total++; if (gnt !== (4'b0001 << g) || rnd_valid !== 1'b1) begin bad++; $display("FAIL rnd_pick cyc=%0d gnt=%b valid=%b exp=%b/1", cyc, gnt, rnd_valid, 4'b0001 << g); end
            end else begin
                total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rnd_idle cyc=%0d gnt=%b exp=0000", cyc, gnt); end
            end
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b1; seed_no = 3'd1; seed_val = '0; reseed = 1'b0;
        req = '0; req_len = '0; rnd_ready = '0;
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_wrap();
        test_reseed_mid();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
